// File: rtl/host_cmd_bridge_pkg.sv
// Shared opcodes and FSM state encoding for the host command bridge.
package host_cmd_bridge_pkg;
    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_DRAIN = 2'd1,
        WR_ISSUE = 2'd2,
        RD_ISSUE = 2'd3
    } state_e;
endpackage

// File: rtl/host_cmd_bridge_if.sv
// Command, accelerator and response signals of the bridge; slave is the bridge view.
interface host_cmd_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              cmd_valid, cmd_ready, cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              acc_write_en, acc_write_rdy;
    logic [ADDR_W-1:0] acc_write_addr;
    logic [DATA_W-1:0] acc_write_data;
    logic              acc_read_en, acc_read_rdy;
    logic [ADDR_W-1:0] acc_read_addr;
    logic              acc_read_data_vld, acc_read_data_rdy;
    logic [DATA_W-1:0] acc_read_data;
    logic              rsp_valid, rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              busy, err_unexp;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, acc_write_rdy, acc_read_rdy,
               acc_read_data_vld, acc_read_data, rsp_ready,
        output cmd_ready, acc_write_en, acc_write_addr, acc_write_data, acc_read_en,
               acc_read_addr, acc_read_data_rdy, rsp_valid, rsp_data, busy, err_unexp
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, acc_write_rdy, acc_read_rdy,
               acc_read_data_vld, acc_read_data, rsp_ready,
        input  cmd_ready, acc_write_en, acc_write_addr, acc_write_data, acc_read_en,
               acc_read_addr, acc_read_data_rdy, rsp_valid, rsp_data, busy, err_unexp
    );
endinterface

// File: rtl/host_cmd_bridge_sync_fifo.sv
// Registered-storage synchronous FIFO; simultaneous push and pop is allowed when full.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/host_cmd_bridge.sv
// Host command front end: splits a write/read command stream onto the accelerator
// handshakes, limits reads in flight to free response-buffer space, returns read data in order.
module host_cmd_bridge
    import host_cmd_bridge_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RSP_DEPTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    host_cmd_bridge_if.slave  bus
);
    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  inflight_q, inflight_d, fifo_cnt, credit;
    logic              rdy_q, err_q;
    logic              load, rd_xfer, data_xfer, push, pop, fifo_full, fifo_empty;

    // Each in-flight read owns a FIFO slot, so credit never goes negative.
    assign credit    = CNT_W'(RSP_DEPTH) - inflight_q - fifo_cnt;
    assign data_xfer = bus.acc_read_data_vld && rdy_q;
    assign push      = data_xfer && (inflight_q != '0) && (!fifo_full || pop);
    assign pop       = !fifo_empty && bus.rsp_ready;
    assign rd_xfer   = bus.acc_read_en && bus.acc_read_rdy;

    assign bus.acc_write_en      = (state_q == WR_ISSUE);
    assign bus.acc_read_en       = (state_q == RD_ISSUE) && (credit != '0);
    assign bus.cmd_ready         = (state_q == IDLE) ||
                                   (bus.acc_write_en && bus.acc_write_rdy) || rd_xfer;
    assign bus.acc_write_addr    = addr_q;
    assign bus.acc_write_data    = data_q;
    assign bus.acc_read_addr     = addr_q;
    assign bus.acc_read_data_rdy = rdy_q;
    assign bus.rsp_valid         = !fifo_empty;
    assign bus.busy              = (state_q != IDLE) || (inflight_q != '0) || !fifo_empty;
    assign bus.err_unexp         = err_q;
    assign load                  = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        inflight_d = inflight_q;
        if (rd_xfer && !push)      inflight_d = inflight_q + CNT_W'(1);
        else if (!rd_xfer && push) inflight_d = inflight_q - CNT_W'(1);
    end

    // Write decisions use the post-update count so a read issued this cycle is drained first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WR_DRAIN: if (inflight_d == '0) state_d = WR_ISSUE;
            WR_ISSUE: if (bus.acc_write_rdy) state_d = IDLE;
            RD_ISSUE: if (rd_xfer) state_d = IDLE;
            default:  ;
        endcase
        if (load) begin
            if (bus.cmd_op == OP_READ)  state_d = RD_ISSUE;
            else if (inflight_d != '0)  state_d = WR_DRAIN;
            else                        state_d = WR_ISSUE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            inflight_q <= '0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            rdy_q      <= 1'b1;
            if (load) begin
                addr_q <= bus.cmd_addr;
                data_q <= bus.cmd_data;
            end
            if (data_xfer && inflight_q == '0) err_q <= 1'b1;
        end
    end

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (bus.acc_read_data),
        .pop_i   (pop),
        .rdata_o (bus.rsp_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );
endmodule

// File: tb/tb_host_cmd_bridge.sv
// Directed and randomized checks of host_cmd_bridge against a command-level reference model.
module tb_host_cmd_bridge;
    import host_cmd_bridge_pkg::*;
    localparam int AW = 32, DW = 32, DEPTH = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    host_cmd_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    host_cmd_bridge #(.ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Controls owned by the main sequence
    int wr_stall_n = 0, rd_delay = 0, rsp_mode = 1, inj_req = 0;
    bit rnd = 0, rrdy_off = 0;

    // Accelerator/consumer model state
    typedef struct { logic [31:0] d; int cnt; } pend_t;
    pend_t pend[$];
    logic [DW-1:0]    rsp_log[$];
    logic [AW+DW-1:0] wr_log[$];
    int nrd_xfer = 0, nret = 0, ord_bad = 0, inj_done = 0, stall_used = 0;
    bit cur_real = 0;

    // Reference expectations
    logic [DW-1:0]    exp_rsp[$];
    logic [AW+DW-1:0] exp_wr[$];
    int rsp_ptr = 0, wr_ptr = 0;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a == 32'h20) ? 32'h1234 : ((a * 32'h0001_9E37) ^ 32'h5A5A_0000);
    endfunction

    // Accelerator and response consumer: observe at negedge, drive just after posedge
    initial begin
        bus.acc_write_rdy = 0; bus.acc_read_rdy = 0; bus.acc_read_data_vld = 0;
        bus.acc_read_data = 0; bus.rsp_ready = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.acc_write_en && bus.acc_write_rdy) begin
                    wr_log.push_back({bus.acc_write_addr, bus.acc_write_data});
                    if (nret != nrd_xfer) ord_bad++;
                    stall_used = 0;
                end
                if (bus.acc_read_en && bus.acc_read_rdy) begin
                    nrd_xfer++;
                    pend.push_back('{memval(bus.acc_read_addr),
                                     rnd ? int'($urandom_range(0, 4)) : rd_delay});
                end
                if (bus.acc_read_data_vld && bus.acc_read_data_rdy && cur_real) nret++;
                if (bus.rsp_valid && bus.rsp_ready) rsp_log.push_back(bus.rsp_data);
            end
            @(posedge clk); #1;
            bus.acc_read_rdy = rrdy_off ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            if (bus.acc_write_en && stall_used < wr_stall_n) begin
                bus.acc_write_rdy = 1'b0;
                stall_used++;
            end else bus.acc_write_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.rsp_ready = (rsp_mode == 2) ? 1'($urandom_range(0, 1)) : (rsp_mode == 1);
            cur_real = 0; bus.acc_read_data_vld = 0; bus.acc_read_data = 0;
            if (!rst_n) begin
                pend.delete(); nrd_xfer = 0; nret = 0;
            end else if (inj_done != inj_req) begin
                inj_done++;
                bus.acc_read_data_vld = 1; bus.acc_read_data = 32'hDEAD;
            end else if (pend.size() > 0 && pend[0].cnt == 0) begin
                bus.acc_read_data_vld = 1; bus.acc_read_data = pend[0].d; cur_real = 1;
                void'(pend.pop_front());
            end
            foreach (pend[i]) if (pend[i].cnt > 0) pend[i].cnt--;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_start(input logic op, input logic [31:0] a, input logic [31:0] d);
        bus.cmd_valid = 1; bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_data = d;
        if (op == OP_READ) exp_rsp.push_back(memval(a));
        else               exp_wr.push_back({a, d});
    endtask

    task automatic send_wait();
        bit ok = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin ok = 1; break; end
            tick();
        end
        if (ok) tick();
        chk("cmd_accept", 64'(ok), 64'(1));
        bus.cmd_valid = 0;
    endtask

    task automatic send(input logic op, input logic [31:0] a, input logic [31:0] d);
        send_start(op, a, d);
        send_wait();
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!bus.busy && pend.size() == 0) begin done = 1; break; end
            tick();
        end
        tick();
        chk("drain", 64'(done), 64'(1));
    endtask

    task automatic check_rsp();
        chk("rsp_count", 64'(rsp_log.size() - rsp_ptr), 64'(exp_rsp.size()));
        for (int i = 0; i < exp_rsp.size(); i++)
            if (rsp_ptr + i < rsp_log.size())
                chk($sformatf("rsp[%0d]", i), 64'(rsp_log[rsp_ptr + i]), 64'(exp_rsp[i]));
        rsp_ptr = rsp_log.size();
        exp_rsp.delete();
    endtask

    task automatic check_wr();
        chk("wr_count", 64'(wr_log.size() - wr_ptr), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size(); i++)
            if (wr_ptr + i < wr_log.size())
                chk($sformatf("wr[%0d]", i), 64'(wr_log[wr_ptr + i]), 64'(exp_wr[i]));
        wr_ptr = wr_log.size();
        exp_wr.delete();
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ctl"}, 64'({bus.cmd_ready, bus.acc_write_en, bus.acc_read_en,
                                bus.acc_read_data_rdy, bus.rsp_valid, bus.busy, bus.err_unexp}),
            64'(7'b1000000));
        chk({tag, "_wr"}, {bus.acc_write_addr, bus.acc_write_data}, 64'(0));
        chk({tag, "_rd"}, {bus.acc_read_addr, bus.rsp_data}, 64'(0));
    endtask

    initial begin
        int cnt_a, cnt_b, ret_c, wen_c, base;
        logic [31:0] vd;
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_addr = 0; bus.cmd_data = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs("reset");
        rst_n = 1;
        tick();

        // 1: write held through three stall cycles
        wr_stall_n = 3;
        send(OP_WRITE, 32'h10, 32'hCAFE);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_wen", 64'(bus.acc_write_en), 64'(1));
            chk("t1_addr_data", {bus.acc_write_addr, bus.acc_write_data}, {32'h10, 32'hCAFE});
            chk("t1_cmd_ready", 64'(bus.cmd_ready), 64'(i == 3));
            tick();
        end
        @(negedge clk);
        chk("t1_wen_off", 64'(bus.acc_write_en), 64'(0));
        wr_stall_n = 0;
        tick();
        check_wr();

        // 2: single read, data two cycles after the transfer
        rd_delay = 2;
        send(OP_READ, 32'h20, 32'h0);
        cnt_a = 0; vd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin cnt_a++; vd = bus.rsp_data; end
            tick();
        end
        chk("t2_valid_cycles", 64'(cnt_a), 64'(1));
        chk("t2_data", 64'(vd), 64'(32'h1234));
        @(negedge clk);
        chk("t2_busy", 64'(bus.busy), 64'(0));
        tick();
        check_rsp();

        // 3: six reads against a stalled consumer, credit caps at four
        @(negedge clk); rsp_mode = 0; rd_delay = 1;
        tick();
        base = nrd_xfer;
        for (int k = 0; k < 5; k++) send(OP_READ, 32'h1000 | ($urandom & 32'hFFF0), 32'h0);
        send_start(OP_READ, 32'h2000 | ($urandom & 32'hFFF0), 32'h0);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.acc_read_en) cnt_a++;
            if (bus.cmd_ready) cnt_b++;
            tick();
        end
        chk("t3_rd_xfers", 64'(nrd_xfer - base), 64'(4));
        chk("t3_read_en_low", 64'(cnt_a), 64'(0));
        chk("t3_cmd_ready_low", 64'(cnt_b), 64'(0));
        @(negedge clk); rsp_mode = 1;
        tick();
        send_wait();
        wait_idle();
        chk("t3_rd_total", 64'(nrd_xfer - base), 64'(6));
        check_rsp();

        // 4: write behind a slow read drains first
        rd_delay = 5;
        send(OP_READ, 32'h3000, 32'h0);
        send(OP_WRITE, 32'h3004, 32'hBEEF);
        ret_c = -10; wen_c = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) chk("t4_state", 64'(dut.state_q), 64'(WR_DRAIN));
            if (bus.acc_read_data_vld && bus.acc_read_data_rdy) ret_c = i;
            if (bus.acc_write_en) begin wen_c = i; break; end
            tick();
        end
        chk("t4_wen_after_ret", 64'(wen_c), 64'(ret_c + 1));
        tick();
        wait_idle();
        check_wr();
        check_rsp();

        // 5: unexpected read data
        @(negedge clk); inj_req++;
        repeat (3) tick();
        @(negedge clk);
        chk("t5_err", 64'(bus.err_unexp), 64'(1));
        chk("t5_fifo_unchanged", 64'({bus.rsp_valid, bus.busy}), 64'(0));
        tick();
        rd_delay = 1;
        send(OP_READ, 32'h4440, 32'h0);
        wait_idle();
        check_rsp();
        chk("t5_err_sticky", 64'(bus.err_unexp), 64'(1));

        // 6: reset with reads in flight and a buffered response
        @(negedge clk); rsp_mode = 0; rd_delay = 0;
        tick();
        send(OP_READ, 32'h5000, 32'h0);
        repeat (4) tick();
        rd_delay = 20;
        send(OP_READ, 32'h5010, 32'h0);
        send(OP_READ, 32'h5020, 32'h0);
        tick();
        @(negedge clk); rrdy_off = 1;
        tick();
        send(OP_READ, 32'h5030, 32'h0);
        @(negedge clk);
        chk("t6_pre_state", 64'(dut.state_q), 64'(RD_ISSUE));
        chk("t6_pre_outs", 64'({bus.acc_read_en, bus.rsp_valid, bus.busy}), 64'(3'b111));
        #2 rst_n = 0;
        #1 check_reset_outs("t6_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1; rrdy_off = 0; rsp_mode = 1;
        exp_rsp.delete(); rsp_ptr = rsp_log.size();
        tick();
        @(negedge clk);
        chk("t6_after", 64'({bus.busy, bus.rsp_valid, bus.err_unexp}), 64'(0));
        tick();

        // Randomized traffic with random stalls and consumer backpressure
        @(negedge clk); rnd = 1; rsp_mode = 2;
        tick();
        for (int k = 0; k < 150; k++) begin
            send(1'($urandom_range(0, 1)), $urandom, $urandom);
            repeat ($urandom_range(0, 2)) tick();
        end
        @(negedge clk); rsp_mode = 1;
        tick();
        wait_idle();
        check_wr();
        check_rsp();
        chk("write_order", 64'(ord_bad), 64'(0));
        chk("err_clear_end", 64'(bus.err_unexp), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
